// File: rtl/ptp_rtc_pkg.sv
// Shared types and defaults for the adjustable PTP real-time clock.
// Used by ptp_rtc_adj and ptp_rtc_slew_step.
package ptp_rtc_pkg;

  localparam int RTC_TS_W     = 64;
  localparam int RTC_FRAC_W   = 32;
  localparam int RTC_SLEW_MAX = 4;
  localparam int REM_W        = 33;

  typedef enum logic {
    IDLE,
    SLEW
  } rtc_state_e;

  // 33 bits so that the negated value of adj_ns = -2^31 still fits.
  typedef logic signed [REM_W-1:0] rem_t;

endpackage

// File: rtl/ptp_rtc_slew_step.sv
// Per-tick slew step: clamps the remaining offset to SLEW_MAX (and, for negative
// offsets, to period_int-1 so the time never stands still or runs backward).
module ptp_rtc_slew_step
  import ptp_rtc_pkg::*;
#(
  parameter int SLEW_MAX = RTC_SLEW_MAX
) (
  input  rem_t       i_rem,
  input  logic [7:0] i_period_int,
  output rem_t       o_slew_term,
  output rem_t       o_rem_next
);

  logic             w_neg;
  logic [REM_W-1:0] w_mag;
  logic [REM_W-1:0] w_period_m1;
  logic [REM_W-1:0] w_limit;
  logic [REM_W-1:0] w_step;

  assign w_neg       = i_rem[REM_W-1];
  assign w_period_m1 = {{(REM_W-8){1'b0}}, i_period_int} - REM_W'(1);

  always_comb begin
    w_mag = w_neg ? unsigned'(-i_rem) : unsigned'(i_rem);
    w_limit = REM_W'(SLEW_MAX);
    if (w_neg && (w_period_m1 < w_limit)) begin
      w_limit = w_period_m1;
    end
    w_step = (w_mag < w_limit) ? w_mag : w_limit;
    o_slew_term = w_neg ? -rem_t'(w_step) : rem_t'(w_step);
    o_rem_next = i_rem - o_slew_term;
  end

endmodule

// File: rtl/ptp_rtc_adj.sv
// Adjustable 64-bit nanosecond PTP clock with integer+fraction tick period, hard
// set, and offset correction. Define RTC_SLEW_EN to slew offsets instead of stepping.
module ptp_rtc_adj
  import ptp_rtc_pkg::*;
#(
  parameter int TS_W            = RTC_TS_W,
  parameter int FRAC_W          = RTC_FRAC_W,
  parameter int PERIOD_INT_RST  = 8,
  parameter int PERIOD_FRAC_RST = 0,
  parameter int SLEW_MAX        = RTC_SLEW_MAX
) (
  input  logic               rtc_clk,
  input  logic               reset,
  input  logic [7:0]         cfg_period_int,
  input  logic [FRAC_W-1:0]  cfg_period_frac,
  input  logic               cfg_period_wr,
  input  logic [TS_W-1:0]    time_set_ns,
  input  logic               time_set_wr,
  input  logic signed [31:0] adj_ns,
  input  logic               adj_valid,
  output logic               adj_ready,
  output logic [TS_W-1:0]    time_ns,
  output logic               slew_active
);

  logic [TS_W-1:0]   r_time;
  logic [FRAC_W-1:0] r_frac;
  logic [FRAC_W-1:0] r_period_frac;
  logic [7:0]        r_period_int;

  logic [FRAC_W:0]   w_frac_sum;
  logic              w_carry;
  logic [TS_W-1:0]   w_delta;
  logic [TS_W-1:0]   w_inc;

  assign w_frac_sum = {1'b0, r_frac} + {1'b0, r_period_frac};
  assign w_carry    = w_frac_sum[FRAC_W];
  assign w_inc      = TS_W'(r_period_int) + TS_W'(w_carry) + w_delta;
  assign time_ns    = r_time;

`ifdef RTC_SLEW_EN
  rtc_state_e r_state;
  rtc_state_e w_state_next;
  rem_t       r_rem;
  rem_t       w_rem_next;
  rem_t       w_slew_term;
  rem_t       w_step_rem;

  ptp_rtc_slew_step #(
    .SLEW_MAX(SLEW_MAX)
  ) u_slew_step (
    .i_rem       (r_rem),
    .i_period_int(r_period_int),
    .o_slew_term (w_slew_term),
    .o_rem_next  (w_step_rem)
  );

  always_ff @(posedge rtc_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
    end
  end

  // A hard set wins over everything: no slew step and no handshake that cycle.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_delta      = '0;
    adj_ready    = 1'b0;
    slew_active  = !reset && (r_state == SLEW);
    if (time_set_wr) begin
      w_state_next = IDLE;
      w_rem_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          adj_ready = !reset;
          if (adj_valid && adj_ready && (adj_ns != '0)) begin
            w_rem_next   = rem_t'(adj_ns);
            w_state_next = SLEW;
          end
        end
        SLEW: begin
          w_delta    = TS_W'(w_slew_term);
          w_rem_next = w_step_rem;
          if (w_step_rem == '0) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end
`else
  logic w_adj_fire;

  // Without slewing the whole offset lands in one tick and may step time backward.
  assign adj_ready   = !reset && !time_set_wr;
  assign slew_active = 1'b0;
  assign w_adj_fire  = adj_valid && adj_ready;
  assign w_delta     = w_adj_fire ? TS_W'(adj_ns) : '0;
`endif

  // Period writes below 2 ns are dropped so a negative slew step can always be taken.
  always_ff @(posedge rtc_clk) begin
    if (reset) begin
      r_time        <= '0;
      r_frac        <= '0;
      r_period_int  <= 8'(PERIOD_INT_RST);
      r_period_frac <= FRAC_W'(PERIOD_FRAC_RST);
    end else begin
      if (cfg_period_wr && (cfg_period_int >= 8'd2)) begin
        r_period_int  <= cfg_period_int;
        r_period_frac <= cfg_period_frac;
      end
      if (time_set_wr) begin
        r_time <= time_set_ns;
        r_frac <= '0;
      end else begin
        r_time <= r_time + w_inc;
        r_frac <= w_frac_sum[FRAC_W-1:0];
      end
    end
  end

endmodule
